// File: rtl/updown_tick_counter_pkg.sv
// Shared constants and helpers for the tick-driven up/down counter family.
// Board clock defaults and the saturate-mode encoding live here.
package updown_tick_counter_pkg;

    // 50 MHz board clock -> one count step per second.
    localparam int DEFAULT_TICK_DIV = 50_000_000;

    localparam int WRAP = 0;
    localparam int SAT  = 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/updown_tick_counter_tick_prescaler.sv
// Clock-enable prescaler: emits a one-cycle step every TICK_DIV clocks while en is high.
// Dropping en clears the phase, so the next step is a full interval away.
module tick_prescaler
    import updown_tick_counter_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic step
);

    localparam int PW_RAW = clog2(TICK_DIV);
    localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;

    assign step = en && (p_q == LAST);

    always_comb begin
        p_d = p_q;
        if (!en) begin
            p_d = '0;
        end else if (p_q == LAST) begin
            p_d = '0;
        end else begin
            p_d = p_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/updown_tick_counter.sv
// Modulo up/down counter advanced by an internal prescaler step, with wrap or
// saturate behaviour at the limits, synchronous load and carry/borrow pulses.
module updown_tick_counter
    import updown_tick_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int SATURATE = WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .step (step)
    );

    // Limits are compared before stepping, so WIDTH-bit overflow never appears.
    always_comb begin
        count_d  = count_q;
        tick_d   = 1'b0;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_W) ? MAX_W : load_val;
        end else if (step) begin
            tick_d = 1'b1;
            if (up && !down) begin
                if (count_q == MAX_W) begin
                    if (SATURATE == WRAP) begin
                        count_d = '0;
                        carry_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else if (down && !up) begin
                if (count_q == '0) begin
                    if (SATURATE == WRAP) begin
                        count_d  = MAX_W;
                        borrow_d = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            tick_q   <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            tick_q   <= tick_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign count  = count_q;
    assign tick   = tick_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;
    assign at_max = (count_q == MAX_W);
    assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_tick_counter.sv
// Bench for updown_tick_counter: three instances (wrap/4, saturate/4, wrap/1)
// share stimulus; a cycle model feeds a scoreboard queue checked after each edge.
module tb_updown_tick_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       down;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] cnt_o    [3];
    logic       tick_o   [3];
    logic       carry_o  [3];
    logic       borrow_o [3];
    logic       at_max_o [3];
    logic       at_min_o [3];

    int checks   = 0;
    int failures = 0;

    int td  [3] = '{4, 4, 1};
    int sat [3] = '{0, 1, 0};
    int m_p   [3];
    int m_cnt [3];

    typedef struct {
        int         inst;
        logic [8:0] v;
    } sb_t;
    sb_t sb_q[$];

    int tick_n  [3];
    int carry_n [3];
    int borrow_n[3];

    updown_tick_counter #(.WIDTH(4), .MAX_VAL(9), .TICK_DIV(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load), .load_val(load_val),
        .count(cnt_o[0]), .tick(tick_o[0]), .carry(carry_o[0]), .borrow(borrow_o[0]),
        .at_max(at_max_o[0]), .at_min(at_min_o[0]));

    updown_tick_counter #(.WIDTH(4), .MAX_VAL(9), .TICK_DIV(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load), .load_val(load_val),
        .count(cnt_o[1]), .tick(tick_o[1]), .carry(carry_o[1]), .borrow(borrow_o[1]),
        .at_max(at_max_o[1]), .at_min(at_min_o[1]));

    updown_tick_counter #(.WIDTH(4), .MAX_VAL(9), .TICK_DIV(1), .SATURATE(0)) dut_fast (
        .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load), .load_val(load_val),
        .count(cnt_o[2]), .tick(tick_o[2]), .carry(carry_o[2]), .borrow(borrow_o[2]),
        .at_max(at_max_o[2]), .at_min(at_min_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] obs(input int i);
        return {cnt_o[i], tick_o[i], carry_o[i], borrow_o[i], at_max_o[i], at_min_o[i]};
    endfunction

    function automatic logic [8:0] model_step(input int i);
        bit   stp;
        logic t, c, b;
        logic [3:0] cv;
        stp = en && (m_p[i] == td[i] - 1);
        t = 1'b0; c = 1'b0; b = 1'b0;
        if (!en || m_p[i] == td[i] - 1) m_p[i] = 0;
        else                             m_p[i] = m_p[i] + 1;
        if (load) begin
            m_cnt[i] = (int'(load_val) > 9) ? 9 : int'(load_val);
        end else if (stp) begin
            t = 1'b1;
            if (up && !down) begin
                if (m_cnt[i] < 9)        m_cnt[i] = m_cnt[i] + 1;
                else if (sat[i] == 0) begin m_cnt[i] = 0; c = 1'b1; end
            end else if (down && !up) begin
                if (m_cnt[i] > 0)        m_cnt[i] = m_cnt[i] - 1;
                else if (sat[i] == 0) begin m_cnt[i] = 9; b = 1'b1; end
            end
        end
        cv = 4'(m_cnt[i]);
        return {cv, t, c, b, (m_cnt[i] == 9), (m_cnt[i] == 0)};
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            tick_n[i] = 0; carry_n[i] = 0; borrow_n[i] = 0;
        end
    endtask

    task automatic cycle();
        sb_t e;
        for (int i = 0; i < 3; i++) begin
            e.inst = i;
            e.v    = model_step(i);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("sb_inst%0d", e.inst), 32'(obs(e.inst)), 32'(e.v));
            tick_n[e.inst]   += int'(tick_o[e.inst]);
            carry_n[e.inst]  += int'(carry_o[e.inst]);
            borrow_n[e.inst] += int'(borrow_o[e.inst]);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int n;
        rst = 1'b0; en = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0; load_val = 4'd0;
        for (int i = 0; i < 3; i++) begin m_p[i] = 0; m_cnt[i] = 0; end
        #12;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_state%0d", i), 32'(obs(i)), 32'(9'b0000_000_01));
        @(negedge clk);
        rst = 1'b1;

        // Count up through the modulo limit.
        clear_counts();
        en = 1'b1; up = 1'b1;
        run(40);
        check("up_ticks", tick_n[0], 10);
        check("up_carries", carry_n[0], 1);
        check("up_final", 32'(cnt_o[0]), 0);

        // Load then count down through zero.
        load = 1'b1; load_val = 4'd3; up = 1'b0;
        cycle();
        check("load3", 32'(cnt_o[0]), 3);
        load = 1'b0; down = 1'b1;
        clear_counts();
        run(20);
        check("down_borrows", borrow_n[0], 1);
        check("down_final", 32'(cnt_o[0]), 8);

        // Saturation at the top and bottom.
        load = 1'b1; load_val = 4'd9; down = 1'b0;
        cycle();
        load = 1'b0; up = 1'b1;
        clear_counts();
        run(12);
        check("sat_hi_count", 32'(cnt_o[1]), 9);
        check("sat_hi_ticks", tick_n[1], 3);
        check("sat_hi_carry", carry_n[1], 0);
        load = 1'b1; load_val = 4'd0; up = 1'b0;
        cycle();
        load = 1'b0; down = 1'b1;
        clear_counts();
        run(12);
        check("sat_lo_count", 32'(cnt_o[1]), 0);
        check("sat_lo_ticks", tick_n[1], 3);
        check("sat_lo_borrow", borrow_n[1], 0);

        // Over-range load clamps; up and down together hold.
        load = 1'b1; load_val = 4'd15; down = 1'b0;
        cycle();
        check("clamp_count", 32'(cnt_o[0]), 9);
        check("clamp_at_max", 32'(at_max_o[0]), 1);
        load = 1'b0; up = 1'b1; down = 1'b1;
        clear_counts();
        run(4);
        check("updown_hold", 32'(cnt_o[0]), 9);
        check("updown_tick", tick_n[0], 1);

        // Drop en at prescaler phase 2; the full interval restarts.
        down = 1'b0;
        n = 0;
        while (m_p[0] != 2 && n < 10) begin cycle(); n++; end
        check("phase_found", 32'(m_p[0]), 2);
        en = 1'b0;
        run(2);
        en = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!tick_o[0] && n < 10);
        check("restart_latency", n, 4);

        // Asynchronous reset between edges.
        load = 1'b1; load_val = 4'd7;
        cycle();
        load = 1'b0; en = 1'b0;
        check("pre_reset_count", 32'(cnt_o[0]), 7);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("async_reset%0d", i), 32'(obs(i)), 32'(9'b0000_000_01));
        for (int i = 0; i < 3; i++) begin m_p[i] = 0; m_cnt[i] = 0; end
        @(negedge clk);
        rst = 1'b1;
        en = 1'b1; up = 1'b1;
        run(12);
        check("resume_count", 32'(cnt_o[0]), 3);

        // Mixed random traffic.
        for (int k = 0; k < 80; k++) begin
            en       = ($urandom_range(0, 7) != 0);
            up       = $urandom_range(0, 1) != 0;
            down     = $urandom_range(0, 1) != 0;
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/updown_tick_counter.md
# updown_tick_counter

Parametrised up/down counter driven by an internal clock-enable prescaler, replacing the fixed 4-bit, divided-clock LED counter. All logic runs on the single system clock; the prescaler produces a one-cycle enable instead of a derived clock. Adds modulo limit, wrap/saturate mode, synchronous load, and carry/borrow/terminal flags. Sits between debounced board switches and LED/7-segment drivers.

## Interface
- WIDTH, 4: counter width in bits.
- MAX_VAL, 2**WIDTH-1: terminal count; count range 0..MAX_VAL. Legal range 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- TICK_DIV, 50_000_000: system clocks per count step. Must be ≥ 1.
- SATURATE, 0: 0 = wrap at the limits, 1 = hold at the limits.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- en  in  1  run enable for prescaler and counting.
- up  in  1  count up on each tick.
- down  in  1  count down on each tick.
- load  in  1  synchronous load request.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- tick  out  1  registered pulse, high for the cycle in which a tick-driven count update becomes visible.
- carry  out  1  registered one-cycle pulse on an up-wrap from MAX_VAL to 0.
- borrow  out  1  registered one-cycle pulse on a down-wrap from 0 to MAX_VAL.
- at_max  out  1  combinational: count == MAX_VAL.
- at_min  out  1  combinational: count == 0.

## Operation
- Prescaler register p has width max(1, clog2(TICK_DIV)).
  - With en=1, p counts 0..TICK_DIV-1 and then returns to 0.
  - With en=0, p is cleared to 0 synchronously.
  - The internal step is `en && p == TICK_DIV-1`. With TICK_DIV=1, step is high every cycle while en=1.
- Counter priority, evaluated each clock:
  1. load=1: count ← min(load_val, MAX_VAL) on any cycle, independent of en and step. No carry or borrow. tick is not asserted. The prescaler is unaffected.
  2. step with up=1, down=0: count+1. At MAX_VAL it goes to 0 with a carry pulse, or holds (no pulse) when SATURATE=1.
  3. step with down=1, up=0: count-1. At 0 it goes to MAX_VAL with a borrow pulse, or holds (no pulse) when SATURATE=1.
  4. step with up=down: count holds.
  5. Otherwise count holds.
- tick pulses on every step, including steps where the count holds (up=down, saturated, or both inputs low).
- carry and borrow are never high in the same cycle.
- All arithmetic is done in WIDTH bits. Intermediate overflow is never exposed because the limit compare happens before increment or decrement.
- Reset values: count=0, tick=0, carry=0, borrow=0, p=0. Hence at_min=1 and at_max=0.
- Reset asserted mid-count clears everything immediately, asynchronously. After release, the first step occurs TICK_DIV cycles after en is seen high.

## Timing
- Step-to-output latency is one clock: count, tick, carry and borrow all update on the same edge.
- Load latency is one clock.
- up and down are sampled only on step cycles. Glitches between steps have no effect.
- With continuous en, step period is exactly TICK_DIV clocks. Dropping en for any number of cycles restarts the full TICK_DIV interval.
- Reset release should be synchronised externally. The block does not re-synchronise it.

## Structure
- Shared package/header holds:
  - default TICK_DIV for the 50 MHz board clock;
  - the clog2 helper;
  - the SATURATE mode constants WRAP=0 and SAT=1.
- One sub-module, `tick_prescaler`, with parameter TICK_DIV and ports clk, rst, en, step. It is reused by other timed blocks.
- The top level holds the counter register, limit compares and flag registers. Expected size is roughly 150–250 lines total.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9, TICK_DIV=4 unless stated otherwise.
- Reset, then en=1 and up=1 for 40 clocks → count steps 0,1,…,9,0 every 4 clocks; carry pulses once on the 9→0 step; tick pulses 10 times.
- load=1 with load_val=3, then down=1 held → count is 3 the next cycle, then 2,1,0,9; borrow pulses on the 0→9 step; at_min is high while count=0.
- SATURATE=1 with count at 9 and up=1 for 3 steps → count stays 9, tick pulses 3 times, carry stays 0. The same applies at 0 with down=1.
- load_val=15 → count=9 and at_max=1. up=down=1 on a step → count holds and tick=1.
- en dropped for 2 cycles at p=2, then restored → the next step occurs 4 clocks after en rises. TICK_DIV=1 run → count changes on every clock.
- rst driven low asynchronously between clock edges at count=7 → count=0 and flags=0 without waiting for a clock edge; counting resumes normally after release.
